power_mode_arbiter: RTL and testbench



---
 rtl/power_mode_pkg.sv | 22 ++
 rtl/pm_vote_resolver.sv | 30 +++
 rtl/power_mode_arbiter.sv | 144 ++++++++++++++
 tb/tb_power_mode_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/power_mode_pkg.sv
// power_mode_pkg: shared definitions for the power-mode arbitration logic.
//   - Mode encodings driven to / reported by the power-domain controller.
//   - Arbiter FSM state encoding.
//   - pm_clamp: folds the reserved vote encoding 2'b11 onto Active.
package power_mode_pkg;

  localparam logic [1:0] PM_DEEPSLEEP = 2'b00;
  localparam logic [1:0] PM_STANDBY   = 2'b01;
  localparam logic [1:0] PM_ACTIVE    = 2'b10;

  typedef enum logic [1:0] {
    PM_ST_IDLE  = 2'd0,
    PM_ST_DWELL = 2'd1,
    PM_ST_WAIT  = 2'd2
  } pm_state_e;

  // A vote of 2'b11 is not a real mode; treat it as the highest real mode.
  function automatic logic [1:0] pm_clamp(input logic [1:0] mode);
    return (mode == 2'b11) ? PM_ACTIVE : mode;
  endfunction

endpackage

// File: rtl/pm_vote_resolver.sv
// pm_vote_resolver: combinational max-reduction of masked power-mode votes.
// Ports:
//   i_req_valid [NUM_REQ]    requester i is voting
//   i_req_mode  [2*NUM_REQ]  vote of requester i in bits [2i+1:2i]
//   o_target    [2]          highest clamped vote among valid requesters,
//                            DeepSleep when nobody votes
module pm_vote_resolver
  import power_mode_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [2*NUM_REQ-1:0] i_req_mode,
  output logic [1:0]           o_target
);

  logic [1:0] w_max;

  always_comb begin
    w_max = PM_DEEPSLEEP;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_req_valid[i] && (pm_clamp(i_req_mode[2*i +: 2]) > w_max)) begin
        w_max = pm_clamp(i_req_mode[2*i +: 2]);
      end
    end
  end

  assign o_target = w_max;

endmodule

// File: rtl/power_mode_arbiter.sv
// power_mode_arbiter: shares the power-domain controller's single mode input
// between NUM_REQ requesters. Upgrades are applied at once, downgrades only
// after a dwell window, and the applied mode is frozen while the controller
// sequences a transition.
// Ports:
//   clk, rst_n         always-on clock, asynchronous active-low reset
//   req_valid          per-requester vote valid (level)
//   req_mode           per-requester vote, 2 bits each
//   dwell_cfg          downgrade dwell in cycles
//   pdc_mode           mode requested from the controller (registered)
//   pdc_current_mode   controller's reported current mode
//   pdc_done           controller transition done
//   req_met            per-requester vote satisfied by the applied mode
//   busy               arbiter is not IDLE
//   err_timeout        sticky: a transition exceeded TIMEOUT_CYCLES
module power_mode_arbiter
  import power_mode_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DWELL_W        = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_mode,
  input  logic [DWELL_W-1:0]   dwell_cfg,
  output logic [1:0]           pdc_mode,
  input  logic [1:0]           pdc_current_mode,
  input  logic                 pdc_done,
  output logic [NUM_REQ-1:0]   req_met,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int                TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [1:0]         w_target;
  logic [1:0]         w_vote [NUM_REQ];
  logic               w_done_ok;

  pm_state_e          r_state;
  logic [DWELL_W-1:0] r_dwell;
  logic [TMO_W-1:0]   r_tmo;
  logic [1:0]         r_pdc_mode;
  logic [NUM_REQ-1:0] r_req_met;
  logic               r_busy;
  logic               r_err;

  pm_vote_resolver #(
    .NUM_REQ (NUM_REQ)
  ) u_resolver (
    .i_req_valid (req_valid),
    .i_req_mode  (req_mode),
    .o_target    (w_target)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_vote[i] = pm_clamp(req_mode[2*i +: 2]);
    end
  end

  // Completion only counts if the controller actually reached what we asked for.
  assign w_done_ok = pdc_done && (pdc_current_mode == r_pdc_mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PM_ST_IDLE;
      r_dwell    <= '0;
      r_tmo      <= '0;
      r_pdc_mode <= PM_ACTIVE;
      r_req_met  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      // Satisfaction is recomputed only when settled; while a change is
      // pending or in flight, a requester can only lose satisfaction.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (r_state == PM_ST_IDLE) begin
          r_req_met[i] <= req_valid[i] && (w_vote[i] <= r_pdc_mode);
        end else if (w_vote[i] > r_pdc_mode) begin
          r_req_met[i] <= 1'b0;
        end
      end

      case (r_state)
        PM_ST_IDLE: begin
          if (w_target > r_pdc_mode) begin
            r_pdc_mode <= w_target;
            r_tmo      <= '0;
            r_state    <= PM_ST_WAIT;
            r_busy     <= 1'b1;
          end else if (w_target < r_pdc_mode) begin
            r_dwell <= dwell_cfg;
            r_state <= PM_ST_DWELL;
            r_busy  <= 1'b1;
          end
        end

        PM_ST_DWELL: begin
          if (w_target >= r_pdc_mode) begin
            r_state <= PM_ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_dwell == '0) begin
            // Issue whatever the target is now, which may be an
            // intermediate mode voted during the dwell.
            r_pdc_mode <= w_target;
            r_tmo      <= '0;
            r_state    <= PM_ST_WAIT;
          end else begin
            r_dwell <= r_dwell - DWELL_W'(1);
          end
        end

        PM_ST_WAIT: begin
          // r_tmo == 0 marks the first WAIT cycle, where done is ignored.
          if ((r_tmo != '0) && w_done_ok) begin
            r_state <= PM_ST_IDLE;
            r_busy  <= 1'b0;
          end else if (r_tmo == TMO_LIMIT) begin
            r_err   <= 1'b1;
            r_state <= PM_ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        default: begin
          r_state <= PM_ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pdc_mode    = r_pdc_mode;
  assign req_met     = r_req_met;
  assign busy        = r_busy;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_power_mode_arbiter.sv
module tb_power_mode_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req_valid;
  logic [7:0]    req_mode;
  logic [15:0]   dwell_cfg;
  logic [1:0]    pdc_mode;
  logic [1:0]    pdc_current_mode;
  logic          pdc_done;
  logic [3:0]    req_met;
  logic          busy;
  logic          err_timeout;

  always #5 clk = ~clk;

  power_mode_arbiter #(
    .NUM_REQ        (NREQ),
    .DWELL_W        (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_mode         (req_mode),
    .dwell_cfg        (dwell_cfg),
    .pdc_mode         (pdc_mode),
    .pdc_current_mode (pdc_current_mode),
    .pdc_done         (pdc_done),
    .req_met          (req_met),
    .busy             (busy),
    .err_timeout      (err_timeout)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Applied mode plus two countdown/age trackers: a pending downgrade
  // (cycles of hold-off left, -1 when none) and an in-flight transition
  // (age in cycles, -1 when none). Settled means neither is active.
  bit         m_on = 1'b0;
  int         m_mode;
  int         m_hold;
  int         m_flight;
  logic [3:0] m_met;
  bit         m_err;

  function automatic int vote_of(input int i);
    int v;
    v = int'(req_mode[2*i +: 2]);
    return (v > 2) ? 2 : v;
  endfunction

  function automatic int want();
    int best;
    best = 0;
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && vote_of(i) > best) best = vote_of(i);
    return best;
  endfunction

  task automatic model_reset();
    m_mode = 2; m_hold = -1; m_flight = -1; m_met = '0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int  tgt;
    int  cur;
    bit  settled;
    tgt     = want();
    cur     = m_mode;
    settled = (m_hold < 0) && (m_flight < 0);
    for (int i = 0; i < NREQ; i++) begin
      if (settled)              m_met[i] = req_valid[i] && (vote_of(i) <= cur);
      else if (vote_of(i) > cur) m_met[i] = 1'b0;
    end
    if (m_flight >= 0) begin
      if (m_flight >= 1 && pdc_done && int'(pdc_current_mode) == cur) m_flight = -1;
      else if (m_flight == TMO) begin m_err = 1'b1; m_flight = -1; end
      else m_flight++;
    end else if (m_hold >= 0) begin
      if (tgt >= cur) m_hold = -1;
      else if (m_hold == 0) begin m_mode = tgt; m_hold = -1; m_flight = 0; end
      else m_hold--;
    end else begin
      if (tgt > cur) begin m_mode = tgt; m_flight = 0; end
      else if (tgt < cur) m_hold = int'(dwell_cfg);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_on) model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_mode = '0; dwell_cfg = '0;
    pdc_done = 1'b0; pdc_current_mode = 2'b10;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_pdc",  int'(pdc_mode), 2);
    check("rst_busy", int'(busy), 0);
    check("rst_met",  int'(req_met), 0);
    check("rst_err",  int'(err_timeout), 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  mode;
    logic [15:0] dwell;
    logic        done;
    logic [1:0]  cur;
    logic [1:0]  e_pdc;
    logic        e_busy;
    logic [3:0]  e_met;
  } vec_t;

  vec_t tbl [13];

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    //          valid    mode         dwell  done  cur    pdc    busy  met
    tbl[0]  = '{4'b0001, 8'b00000010, 16'd0, 1'b0, 2'b10, 2'b10, 1'b0, 4'b0001};
    tbl[1]  = '{4'b0001, 8'b00000000, 16'd0, 1'b0, 2'b10, 2'b10, 1'b1, 4'b0001};
    tbl[2]  = '{4'b0001, 8'b00000000, 16'd0, 1'b0, 2'b10, 2'b00, 1'b1, 4'b0001};
    tbl[3]  = '{4'b0001, 8'b00000000, 16'd0, 1'b1, 2'b00, 2'b00, 1'b1, 4'b0001};
    tbl[4]  = '{4'b0001, 8'b00000000, 16'd0, 1'b1, 2'b00, 2'b00, 1'b0, 4'b0001};
    tbl[5]  = '{4'b0100, 8'b00100000, 16'd0, 1'b0, 2'b00, 2'b10, 1'b1, 4'b0000};
    tbl[6]  = '{4'b0100, 8'b00100000, 16'd0, 1'b0, 2'b00, 2'b10, 1'b1, 4'b0000};
    tbl[7]  = '{4'b0100, 8'b00100000, 16'd0, 1'b1, 2'b01, 2'b10, 1'b1, 4'b0000};
    tbl[8]  = '{4'b0100, 8'b00100000, 16'd0, 1'b1, 2'b10, 2'b10, 1'b0, 4'b0000};
    tbl[9]  = '{4'b0100, 8'b00100000, 16'd0, 1'b0, 2'b10, 2'b10, 1'b0, 4'b0100};
    tbl[10] = '{4'b1111, 8'b00011100, 16'd0, 1'b0, 2'b10, 2'b10, 1'b0, 4'b1111};
    tbl[11] = '{4'b0001, 8'b00000001, 16'd3, 1'b0, 2'b10, 2'b10, 1'b1, 4'b0001};
    tbl[12] = '{4'b0001, 8'b00000010, 16'd3, 1'b0, 2'b10, 2'b10, 1'b0, 4'b0001};

    do_reset();
    for (int k = 0; k < 13; k++) begin
      req_valid = tbl[k].valid; req_mode = tbl[k].mode; dwell_cfg = tbl[k].dwell;
      pdc_done = tbl[k].done; pdc_current_mode = tbl[k].cur;
      tick();
      check($sformatf("tbl%0d_pdc", k),  int'(pdc_mode), int'(tbl[k].e_pdc));
      check($sformatf("tbl%0d_busy", k), int'(busy),     int'(tbl[k].e_busy));
      check($sformatf("tbl%0d_met", k),  int'(req_met),  int'(tbl[k].e_met));
    end

    // Downgrade after reset with a 10-cycle dwell: 01 appears at edge 12.
    do_reset();
    req_valid = 4'b0001; req_mode = 8'b00000001; dwell_cfg = 16'd10;
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("dn_pdc_e%0d", e), int'(pdc_mode), (e < 12) ? 2 : 1);
      if (e == 1) check("dn_busy_e1", int'(busy), 1);
    end
    pdc_done = 1'b1; pdc_current_mode = 2'b01;
    tick();
    check("dn_wait_first", int'(busy), 1);
    tick();
    check("dn_done_busy", int'(busy), 0);
    tick();
    check("dn_met0", int'(req_met[0]), 1);
    pdc_done = 1'b0;

    // Upgrade with the controller stalled: timeout after TMO+1 WAIT cycles.
    req_valid = 4'b0100; req_mode = 8'b00100000; pdc_current_mode = 2'b01;
    tick();
    check("to_pdc_up", int'(pdc_mode), 2);
    check("to_busy_up", int'(busy), 1);
    check("to_met2_up", int'(req_met[2]), 0);
    for (int e = 2; e <= TMO + 1; e++) tick();
    check("to_err_early", int'(err_timeout), 0);
    check("to_busy_early", int'(busy), 1);
    tick();
    check("to_err_set", int'(err_timeout), 1);
    check("to_busy_clr", int'(busy), 0);
    check("to_pdc_kept", int'(pdc_mode), 2);
    repeat (5) tick();
    check("to_err_sticky", int'(err_timeout), 1);
    check("to_met2_idle", int'(req_met[2]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("to_async_err", int'(err_timeout), 0);
    check("to_async_met", int'(req_met), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Intermediate vote during dwell, then votes frozen during WAIT.
    do_reset();
    req_valid = 4'b0001; req_mode = 8'b00000000; dwell_cfg = 16'd4;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check($sformatf("im_pdc_e%0d", e), int'(pdc_mode), 2);
    end
    req_valid = 4'b0011; req_mode = 8'b00000100;
    tick(); check("im_pdc_e4", int'(pdc_mode), 2);
    tick(); check("im_pdc_e5", int'(pdc_mode), 2);
    tick(); check("im_pdc_e6", int'(pdc_mode), 1);
    req_valid = 4'b1011; req_mode = 8'b10000100;
    for (int e = 0; e < 5; e++) begin
      tick();
      check($sformatf("fz_pdc_%0d", e),  int'(pdc_mode), 1);
      check($sformatf("fz_met3_%0d", e), int'(req_met[3]), 0);
    end
    pdc_done = 1'b1; pdc_current_mode = 2'b01;
    tick();
    check("fz_idle_busy", int'(busy), 0);
    check("fz_idle_pdc", int'(pdc_mode), 1);
    tick();
    check("fz_up_pdc", int'(pdc_mode), 2);
    check("fz_up_met3", int'(req_met[3]), 0);
    pdc_current_mode = 2'b10;
    tick(); tick(); tick();
    check("fz_end_met3", int'(req_met[3]), 1);

    // Randomized run against the model.
    do_reset();
    m_on = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        req_valid = 4'($urandom);
        req_mode  = 8'($urandom);
      end
      if ($urandom_range(0, 31) == 0) dwell_cfg = 16'($urandom_range(0, 6));
      pdc_done = ($urandom_range(0, 2) == 0);
      pdc_current_mode = ($urandom_range(0, 3) != 0) ? 2'(m_mode) : 2'($urandom_range(0, 3));
      tick();
      check("rnd_pdc",  int'(pdc_mode),    m_mode);
      check("rnd_busy", int'(busy),        (m_hold >= 0 || m_flight >= 0) ? 1 : 0);
      check("rnd_met",  int'(req_met),     int'(m_met));
      check("rnd_err",  int'(err_timeout), int'(m_err));
    end
    m_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
